// File: rtl/regbank_sequencer.sv
// regbank_sequencer
//   Buffers 32-bit instruction words in a small FIFO and issues them one at a
//   time to the register bank / ALU datapath, holding the decoded fields for
//   EXEC_CYCLES cycles and strobing the bank write on the last one. Each
//   retired instruction is reported with a one-cycle res_valid pulse.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   instr_valid/ready  instruction handshake (ready == FIFO not full)
//   instr              [31:28] op, [27:24] rd, [23:20] rs1, [19:16] rs2, [15:0] imm
//   resume             one-cycle pulse releasing the HALTED state
//   rb_load, rb_din    bank write source select and immediate data
//   rb_op, rb_rs1, rb_rs2, rb_rd   ALU op and register addresses
//   rb_en              bank write enable (one cycle per instruction)
//   rb_out             bank ALU result (combinational from rs1/rs2/op)
//   res_valid/data/rd  retire report
//   busy, count        activity flag and FIFO occupancy
module regbank_sequencer #(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned EXEC_CYCLES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     instr_valid,
   output logic                     instr_ready,
   input  logic [31:0]              instr,
   input  logic                     resume,
   output logic                     rb_load,
   output logic [31:0]              rb_din,
   output logic [3:0]               rb_op,
   output logic [3:0]               rb_rs1,
   output logic [3:0]               rb_rs2,
   output logic [3:0]               rb_rd,
   output logic                     rb_en,
   input  logic [31:0]              rb_out,
   output logic                     res_valid,
   output logic [31:0]              res_data,
   output logic [3:0]               res_rd,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned CNTW = $clog2(DEPTH) + 1;
   localparam int unsigned CW   = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

   localparam logic [CW-1:0]   LAST_CYC = CW'(EXEC_CYCLES - 1);
   localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
   localparam logic [3:0]      OP_LOAD  = 4'b0000;
   localparam logic [3:0]      OP_HALT  = 4'b1111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_RETIRE,
      S_HALTED
   } state_e;

   // ---------------------------------------------------------------- FIFO
   logic [31:0]     mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0] count_q, count_d;
   logic            push, pop;
   logic [31:0]     head;

   state_e          state_q;

   assign instr_ready = (count_q != FULL_CNT);
   assign push        = instr_valid && instr_ready;
   assign pop         = (state_q == S_IDLE) && (count_q != '0);
   assign head        = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CNTW'(1);
      else if (pop && !push) count_d = count_q - CNTW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= instr;
   end

   // ---------------------------------------------------------------- FSM
   logic [3:0]    h_op, h_rd, h_rs1, h_rs2;
   logic [15:0]   h_imm;
   logic [CW-1:0] cyc_q;
   logic          rb_load_q, rb_en_q, res_valid_q;
   logic [31:0]   rb_din_q, res_data_q;
   logic [3:0]    rb_op_q, rb_rs1_q, rb_rs2_q, rb_rd_q, res_rd_q;

   assign h_op  = head[31:28];
   assign h_rd  = head[27:24];
   assign h_rs1 = head[23:20];
   assign h_rs2 = head[19:16];
   assign h_imm = head[15:0];

   // The rb_* registers are loaded straight from the decoded FIFO head on the
   // pop edge so the fields are valid from the first EXEC cycle; they double
   // as the instruction register for the rest of the instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cyc_q       <= '0;
         rb_load_q   <= 1'b0;
         rb_din_q    <= '0;
         rb_op_q     <= '0;
         rb_rs1_q    <= '0;
         rb_rs2_q    <= '0;
         rb_rd_q     <= '0;
         rb_en_q     <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_rd_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pop) begin
                  if (h_op == OP_HALT) begin
                     state_q <= S_HALTED;
                  end else begin
                     state_q   <= S_EXEC;
                     cyc_q     <= '0;
                     rb_load_q <= (h_op == OP_LOAD);
                     rb_din_q  <= (h_op == OP_LOAD) ? {16'b0, h_imm} : '0;
                     rb_op_q   <= h_op;
                     rb_rs1_q  <= h_rs1;
                     rb_rs2_q  <= h_rs2;
                     rb_rd_q   <= h_rd;
                     rb_en_q   <= (EXEC_CYCLES == 1);
                  end
               end
            end
            S_EXEC: begin
               if (cyc_q == LAST_CYC) begin
                  // rb_out is sampled on the same edge the bank writes.
                  state_q     <= S_RETIRE;
                  res_valid_q <= 1'b1;
                  res_data_q  <= rb_load_q ? rb_din_q : rb_out;
                  res_rd_q    <= rb_rd_q;
                  rb_load_q   <= 1'b0;
                  rb_din_q    <= '0;
                  rb_op_q     <= '0;
                  rb_rs1_q    <= '0;
                  rb_rs2_q    <= '0;
                  rb_rd_q     <= '0;
                  rb_en_q     <= 1'b0;
               end else begin
                  cyc_q   <= cyc_q + CW'(1);
                  rb_en_q <= ((cyc_q + CW'(1)) == LAST_CYC);
               end
            end
            S_RETIRE: begin
               res_valid_q <= 1'b0;
               state_q     <= S_IDLE;
            end
            S_HALTED: begin
               if (resume) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rb_load   = rb_load_q;
   assign rb_din    = rb_din_q;
   assign rb_op     = rb_op_q;
   assign rb_rs1    = rb_rs1_q;
   assign rb_rs2    = rb_rs2_q;
   assign rb_rd     = rb_rd_q;
   assign rb_en     = rb_en_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_rd    = res_rd_q;
   assign busy      = (state_q != S_IDLE) || (count_q != '0);
   assign count     = count_q;

endmodule

// File: doc/regbank_sequencer.md
# regbank_sequencer

Instruction sequencer for the register bank / ALU datapath. It accepts 32-bit instruction words over a valid/ready handshake and buffers them in a small FIFO. It issues them one at a time by driving the bank's `load`, `din`, `op`, `rs1`, `rs2` and `rd` fields plus a one-cycle write strobe, then reports each retired result. It sits between the fetch/test source and the register bank, replacing hand-driven stimulus of those fields.

## Interface
- `DEPTH`, 4: instruction FIFO entries; power of 2, ≥2.
- `EXEC_CYCLES`, 2: cycles fields are held per instruction; ≥1. Write strobe fires on the last one.

- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  reset. Asynchronous and active-high.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  FIFO can accept; equals !full.
- `instr`  in  32  [31:28] op, [27:24] rd, [23:20] rs1, [19:16] rs2, [15:0] imm.
- `resume`  in  1  one-cycle pulse releasing HALTED.
- `rb_load`  out  1  bank selects `rb_din` (1) or ALU result (0) for write.
- `rb_din`  out  32  zero-extended imm.
- `rb_op`  out  4  ALU op to bank.
- `rb_rs1`, `rb_rs2`, `rb_rd`  out  4 each  register addresses.
- `rb_en`  out  1  bank write enable; bank writes `rd` only on edges where high.
- `rb_out`  in  32  bank ALU output (combinational from rs1/rs2/op).
- `res_valid`  out  1  one-cycle retire pulse.
- `res_data`  out  32  retired value.
- `res_rd`  out  4  retired destination.
- `busy`  out  1  state ≠ IDLE or FIFO non-empty.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Op decode: 4'b0000 = LOAD (rb_load=1, rb_din={16'b0,imm}, rb_op=0); 4'b1111 = HALT; all other ops pass through to `rb_op` unmodified with rb_load=0, rb_din=0.
- FIFO: push on instr_valid && instr_ready; pop only in IDLE when non-empty. Pointers wrap modulo DEPTH; `count` is exact, 0..DEPTH. No fall-through. A word pushed into an empty FIFO is popped on the following edge at the earliest.
- States: IDLE, EXEC, RETIRE, HALTED.
- IDLE: if !empty, pop head into the instruction register. Go to HALTED if op==1111, else to EXEC with the cycle counter at 0. Stay in IDLE if empty.
- EXEC: drive rb_* fields from the instruction register and increment the counter. When counter == EXEC_CYCLES-1:
  - rb_en=1 for that cycle only.
  - Capture res_data (imm for LOAD, `rb_out` otherwise, sampled before the write edge) and res_rd = rd.
  - Go to RETIRE.
- RETIRE: res_valid=1 for one cycle, then go to IDLE.
- HALTED: all rb_* held 0 and no res_valid. The FIFO keeps accepting. `resume` high moves the FSM to IDLE; `resume` in any other state is ignored.
- Outside EXEC, all rb_* outputs are 0, never high-Z.
- rd==rs1 or rd==rs2 is legal; a single rb_en pulse guarantees exactly one write.

## Timing
- Reset, asynchronous, effective immediately:
  - state=IDLE, FIFO empty, count=0, instr_ready=1 (asserted during reset).
  - All rb_*=0, res_valid=0, res_data=0, res_rd=0, busy=0.
- Reset mid-EXEC: rb_en drops immediately, no bank write, no res_valid. The instruction and all FIFO contents are discarded.
- Per instruction: pop edge → EXEC_CYCLES cycles of EXEC → 1 cycle RETIRE → IDLE. Back-to-back issue gives an rb_en period of EXEC_CYCLES+2 cycles.
- res_valid rises the cycle after the rb_en cycle.
- Full FIFO: instr_ready=0 and a push attempt is dropped with no state change. In the same edge as a pop, ready is still low, so there is no simultaneous push.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, order preserved.
- HALT consumes one FIFO slot and produces no result.

## Test plan
- Reset, push LOAD r1=20, r2=10, r3=50 → three rb_en single-cycle pulses with rb_load=1 and rb_din 20/10/50, spaced EXEC_CYCLES+2 apart; res_data 20,10,50 with res_rd 1,2,3.
- Push op 0001 rd=5 rs1=1 rs2=2 with the bank model returning 30 → rb_op=1, rs1=1, rs2=2, one rb_en; res_valid with res_data=30, res_rd=5 exactly EXEC_CYCLES+1 cycles after the pop edge.
- Push HALT then 4 ops → count reaches 4 and instr_ready=0; a fifth push is dropped. Pulse `resume` → the 4 ops issue in order and count returns to 0.
- Stream 8 ops with instr_valid held high → no loss or reorder, never more than DEPTH buffered, busy deasserts 1 cycle after the last RETIRE.
- Op 0010 rd=rs1=3, rs2=2 with the model returning 40 → exactly one rb_en; res_data=40.
- Assert rst during the EXEC cycle with rb_en high → rb_en=0 immediately, count=0, no res_valid; after release, a new LOAD executes normally.
